// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit seven-segment driver with frame-latched digits and
// leading-zero blanking. Optional blink support is built when SEG7_BLINK_EN is defined.
module seg7_scan #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       blank_en,
  input  logic [3:0] dp_mask,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PresLast = PW'(REFRESH_DIV - 1);
  localparam logic Inv = (ACTIVE_LOW != 0);

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0]      shdp_q, shdp_d;
  logic            load_pending_q;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            tc;
  logic            frame_wrap;
  logic            load;
  logic [3:0]      lz;
  logic [3:0]      cur;
  logic [6:0]      code;

  always_comb begin
    tc         = (presc_q == PresLast);
    frame_wrap = tc && (idx_q == 2'd3);
    presc_d    = tc ? '0 : presc_q + 1'b1;
    idx_d      = tc ? idx_q + 2'd1 : idx_q;
    load       = load_pending_q || frame_wrap;
    sh_d       = load ? {d3, d2, d1, d0} : sh_q;
    shdp_d     = load ? dp_mask : shdp_q;
  end

  // Blanking follows the latched frame so a digit never flickers mid-frame.
  always_comb begin
    lz    = 4'b0000;
    lz[3] = (sh_q[3] == 4'd0);
    lz[2] = lz[3] && (sh_q[2] == 4'd0);
    lz[1] = lz[2] && (sh_q[1] == 4'd0);
  end

  always_comb begin
    cur = sh_q[idx_q];
    case (cur)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h40;
    endcase
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] FrameLast = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (fcnt_q == FrameLast) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = blink;
`endif

  always_comb begin
    an_d  = 4'b0000;
    seg_d = 7'h00;
    dp_d  = 1'b0;
    if (!load_pending_q && !(blank_en && lz[idx_q])) begin
      an_d  = 4'b0001 << idx_q;
      seg_d = code;
      dp_d  = shdp_q[idx_q];
    end
`ifdef SEG7_BLINK_EN
    if (blink && !phase_q) an_d = 4'b0000;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      idx_q          <= 2'd0;
      sh_q           <= '0;
      shdp_q         <= 4'b0000;
      load_pending_q <= 1'b1;
      an_q           <= 4'b0000;
      seg_q          <= 7'h00;
      dp_q           <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      sh_q           <= sh_d;
      shdp_q         <= shdp_d;
      load_pending_q <= 1'b0;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an  = an_q ^ {4{Inv}};
  assign seg = seg_q ^ {7{Inv}};
  assign dp  = dp_q ^ Inv;

endmodule
